// File: rtl/lsu_arb.sv
// -----------------------------------------------------------------------------
// lsu_arb
//
// Purpose:
//   Shares one memory/IO port between a fetch requester (if_*, loads only)
//   and a data requester (dm_*, loads and stores). At most one transaction
//   is in flight: a grant is issued combinationally from IDLE, and the
//   response is returned on the following cycle from RSP_IF or RSP_DM.
//   A 1-bit last-winner register gives round-robin fairness when both
//   requesters are pending. A saturating counter records how many IDLE
//   cycles saw both requests pending.
//
// Handshake:
//   A requester raises x_req_i with stable address/data/we and keeps them
//   stable until x_gnt_o is seen high in the same cycle. The grant cycle is
//   the transfer cycle; nothing is latched before it. Exactly one cycle
//   after a grant, x_rvalid_o is high for one cycle with the load data
//   (or 0 for a store acknowledge). A request dropped before its grant is
//   simply ignored.
//
// Ports:
//   clk_i        clock, all state on rising edge
//   rst_ni       asynchronous active-low reset
//   if_req_i     fetch read request
//   if_addr_i    fetch read address
//   if_gnt_o     fetch request accepted this cycle
//   if_rvalid_o  fetch read data valid
//   if_rdata_o   fetch read data (0 when if_rvalid_o is low)
//   dm_req_i     data request
//   dm_we_i      data request is a store (1) or load (0)
//   dm_addr_i    data address
//   dm_wdata_i   data store value
//   dm_gnt_o     data request accepted this cycle
//   dm_rvalid_o  data response valid (load data or store ack)
//   dm_rdata_o   data load value (0 for stores / when idle)
//   mem_addr_o   shared port address (0 when no grant)
//   mem_wdata_o  shared port store data (0 when no grant)
//   mem_st_en_o  shared port store enable (dm store grant cycle only)
//   mem_rdata_i  shared port load data, valid one cycle after the address
//   conf_cnt_o   saturating count of IDLE cycles with both requests pending
//   state_o      debug view of the FSM: 0 = IDLE, 1 = RSP_IF, 2 = RSP_DM
// -----------------------------------------------------------------------------
module lsu_arb #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32,
   parameter int unsigned CW = 16
) (
   input  logic          clk_i,
   input  logic          rst_ni,

   input  logic          if_req_i,
   input  logic [AW-1:0] if_addr_i,
   output logic          if_gnt_o,
   output logic          if_rvalid_o,
   output logic [DW-1:0] if_rdata_o,

   input  logic          dm_req_i,
   input  logic          dm_we_i,
   input  logic [AW-1:0] dm_addr_i,
   input  logic [DW-1:0] dm_wdata_i,
   output logic          dm_gnt_o,
   output logic          dm_rvalid_o,
   output logic [DW-1:0] dm_rdata_o,

   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   output logic          mem_st_en_o,
   input  logic [DW-1:0] mem_rdata_i,

   output logic [CW-1:0] conf_cnt_o,
   output logic [1:0]    state_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RSP_IF = 2'b01,
      RSP_DM = 2'b10
   } state_e;

   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   state_e        state_q, state_d;
   logic          last_dm_q;   // 1: dm won the most recent grant, 0: if did
   logic          dm_st_q;     // the dm transaction in flight is a store
   logic [CW-1:0] conf_cnt_q;

   logic          pick_if;
   logic          pick_dm;
   logic          conflict;

   // ---------------------------------------------------------------------------
   // Arbitration. Only IDLE can grant. The decision is also gated by rst_ni so
   // that no grant (and no memory-port activity) appears while reset is held,
   // even though the requests reach this logic combinationally.
   // ---------------------------------------------------------------------------
   always_comb begin
      pick_if  = 1'b0;
      pick_dm  = 1'b0;
      conflict = 1'b0;
      if (rst_ni && (state_q == IDLE)) begin
         conflict = if_req_i & dm_req_i;
         if (conflict) begin
            // Whoever did not win last time wins now.
            pick_dm = ~last_dm_q;
            pick_if = last_dm_q;
         end else begin
            // A lone requester wins regardless of history.
            pick_dm = dm_req_i;
            pick_if = if_req_i;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next state and outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      if_gnt_o    = 1'b0;
      dm_gnt_o    = 1'b0;
      if_rvalid_o = 1'b0;
      dm_rvalid_o = 1'b0;
      if_rdata_o  = '0;
      dm_rdata_o  = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_st_en_o = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pick_dm) begin
               dm_gnt_o    = 1'b1;
               mem_addr_o  = dm_addr_i;
               mem_wdata_o = dm_wdata_i;
               mem_st_en_o = dm_we_i;
               state_d     = RSP_DM;
            end else if (pick_if) begin
               if_gnt_o    = 1'b1;
               mem_addr_o  = if_addr_i;
               state_d     = RSP_IF;
            end
         end

         RSP_IF: begin
            if_rvalid_o = 1'b1;
            if_rdata_o  = mem_rdata_i;
            state_d     = IDLE;
         end

         RSP_DM: begin
            dm_rvalid_o = 1'b1;
            // A store is acknowledged with zero data, not with whatever the
            // memory happens to present this cycle.
            dm_rdata_o  = dm_st_q ? '0 : mem_rdata_i;
            state_d     = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         last_dm_q  <= 1'b0;   // "if" won last, so dm takes the first conflict
         dm_st_q    <= 1'b0;
         conf_cnt_q <= '0;
      end else begin
         state_q <= state_d;

         if (pick_if || pick_dm) begin
            last_dm_q <= pick_dm;
         end

         if (pick_dm) begin
            dm_st_q <= dm_we_i;
         end

         if (conflict && (conf_cnt_q != CNT_MAX)) begin
            conf_cnt_q <= conf_cnt_q + CNT_ONE;
         end
      end
   end

   assign conf_cnt_o = conf_cnt_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_lsu_arb.sv
// -----------------------------------------------------------------------------
// tb_lsu_arb
//
// Self-checking bench for lsu_arb. A second instance with a 2-bit conflict
// counter shares all inputs with the main instance to exercise saturation.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_lsu_arb;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 16;
   localparam int unsigned CW_SAT = 2;

   localparam logic [1:0] ST_IDLE = 2'd0;

   localparam int WHO_NONE = 0;
   localparam int WHO_IF   = 1;
   localparam int WHO_DM   = 2;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic clk_i = 1'b0;
   logic rst_ni;

   always #5 clk_i = ~clk_i;

   // ---------------------------------------------------------------------------
   // DUT signals
   // ---------------------------------------------------------------------------
   logic              if_req_i;
   logic [AW-1:0]     if_addr_i;
   logic              if_gnt_o;
   logic              if_rvalid_o;
   logic [DW-1:0]     if_rdata_o;
   logic              dm_req_i;
   logic              dm_we_i;
   logic [AW-1:0]     dm_addr_i;
   logic [DW-1:0]     dm_wdata_i;
   logic              dm_gnt_o;
   logic              dm_rvalid_o;
   logic [DW-1:0]     dm_rdata_o;
   logic [AW-1:0]     mem_addr_o;
   logic [DW-1:0]     mem_wdata_o;
   logic              mem_st_en_o;
   logic [DW-1:0]     mem_rdata_i;
   logic [CW-1:0]     conf_cnt_o;
   logic [1:0]        state_o;

   logic              sat_if_gnt;
   logic              sat_if_rvalid;
   logic [DW-1:0]     sat_if_rdata;
   logic              sat_dm_gnt;
   logic              sat_dm_rvalid;
   logic [DW-1:0]     sat_dm_rdata;
   logic [AW-1:0]     sat_mem_addr;
   logic [DW-1:0]     sat_mem_wdata;
   logic              sat_mem_st_en;
   logic [CW_SAT-1:0] sat_conf_cnt;
   logic [1:0]        sat_state;

   lsu_arb #(.AW(AW), .DW(DW), .CW(CW)) u_dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .if_req_i    (if_req_i),
      .if_addr_i   (if_addr_i),
      .if_gnt_o    (if_gnt_o),
      .if_rvalid_o (if_rvalid_o),
      .if_rdata_o  (if_rdata_o),
      .dm_req_i    (dm_req_i),
      .dm_we_i     (dm_we_i),
      .dm_addr_i   (dm_addr_i),
      .dm_wdata_i  (dm_wdata_i),
      .dm_gnt_o    (dm_gnt_o),
      .dm_rvalid_o (dm_rvalid_o),
      .dm_rdata_o  (dm_rdata_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_st_en_o (mem_st_en_o),
      .mem_rdata_i (mem_rdata_i),
      .conf_cnt_o  (conf_cnt_o),
      .state_o     (state_o)
   );

   lsu_arb #(.AW(AW), .DW(DW), .CW(CW_SAT)) u_dut_sat (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .if_req_i    (if_req_i),
      .if_addr_i   (if_addr_i),
      .if_gnt_o    (sat_if_gnt),
      .if_rvalid_o (sat_if_rvalid),
      .if_rdata_o  (sat_if_rdata),
      .dm_req_i    (dm_req_i),
      .dm_we_i     (dm_we_i),
      .dm_addr_i   (dm_addr_i),
      .dm_wdata_i  (dm_wdata_i),
      .dm_gnt_o    (sat_dm_gnt),
      .dm_rvalid_o (sat_dm_rvalid),
      .dm_rdata_o  (sat_dm_rdata),
      .mem_addr_o  (sat_mem_addr),
      .mem_wdata_o (sat_mem_wdata),
      .mem_st_en_o (sat_mem_st_en),
      .mem_rdata_i (mem_rdata_i),
      .conf_cnt_o  (sat_conf_cnt),
      .state_o     (sat_state)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard bookkeeping
   // ---------------------------------------------------------------------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, want);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic clear_inputs();
      if_req_i    = 1'b0;
      if_addr_i   = '0;
      dm_req_i    = 1'b0;
      dm_we_i     = 1'b0;
      dm_addr_i   = '0;
      dm_wdata_i  = '0;
      mem_rdata_i = '0;
   endtask

   // Advance to just after the next rising edge, where inputs are changed.
   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   // Hold reset over two edges and release it just after a rising edge, so
   // the cycle in which this task returns is the first cycle with rst_ni high.
   task automatic do_reset();
      rst_ni = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
   endtask

   // ---------------------------------------------------------------------------
   // Protocol monitor: runs on every sampled cycle outside reset.
   // ---------------------------------------------------------------------------
   logic prev_if_gnt = 1'b0;
   logic prev_dm_gnt = 1'b0;

   always @(negedge clk_i) begin
      if (!rst_ni) begin
         prev_if_gnt = 1'b0;
         prev_dm_gnt = 1'b0;
      end else begin
         chk("mon_gnt_mutex",    64'(if_gnt_o & dm_gnt_o), 64'd0);
         chk("mon_rvalid_mutex", 64'(if_rvalid_o & dm_rvalid_o), 64'd0);
         chk("mon_st_en_legal",  64'(mem_st_en_o & ~(dm_gnt_o & dm_we_i)), 64'd0);
         chk("mon_if_rsp_after_gnt", 64'(if_rvalid_o), 64'(prev_if_gnt));
         chk("mon_dm_rsp_after_gnt", 64'(dm_rvalid_o), 64'(prev_dm_gnt));
         prev_if_gnt = if_gnt_o;
         prev_dm_gnt = dm_gnt_o;
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus table: applied in order straight after a reset, so the
   // round-robin history carries from one row to the next. Each row is a
   // request cycle followed by a response cycle with all requests dropped.
   // ---------------------------------------------------------------------------
   typedef struct {
      logic          if_req;
      logic [AW-1:0] if_addr;
      logic          dm_req;
      logic          dm_we;
      logic [AW-1:0] dm_addr;
      logic [DW-1:0] dm_wdata;
      logic [DW-1:0] mem_rdata;   // presented in the response cycle
      logic          exp_if_gnt;
      logic          exp_dm_gnt;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_wdata;
      logic          exp_st;
      logic [1:0]    exp_rsp;     // 0 none, 1 if, 2 dm
      logic [DW-1:0] exp_rdata;
   } vec_t;

   localparam int N_VEC = 8;
   vec_t vecs [N_VEC];

   // ---------------------------------------------------------------------------
   // Reference model for random traffic. Expected responses wait in exp_q as
   // {is_dm, is_store}; the port is busy while a response is owed.
   // ---------------------------------------------------------------------------
   logic [1:0] exp_q[$];
   int         m_last_who;
   int         m_conf;
   logic       m_if_granted;
   logic       m_dm_granted;

   task automatic model_reset();
      exp_q.delete();
      m_last_who   = WHO_IF;
      m_conf       = 0;
      m_if_granted = 1'b0;
      m_dm_granted = 1'b0;
   endtask

   task automatic model_check();
      int            who;
      logic [1:0]    rsp;
      logic          e_if_gnt, e_dm_gnt, e_st, e_if_rv, e_dm_rv;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata, e_if_rd, e_dm_rd;
      int            sat_max;

      sat_max = (1 << CW_SAT) - 1;
      chk("rnd_conf_cnt", 64'(conf_cnt_o), 64'((m_conf > 65535) ? 65535 : m_conf));
      chk("rnd_conf_cnt_sat", 64'(sat_conf_cnt), 64'((m_conf > sat_max) ? sat_max : m_conf));

      who      = WHO_NONE;
      e_if_gnt = 1'b0;
      e_dm_gnt = 1'b0;
      e_st     = 1'b0;
      e_if_rv  = 1'b0;
      e_dm_rv  = 1'b0;
      e_addr   = '0;
      e_wdata  = '0;
      e_if_rd  = '0;
      e_dm_rd  = '0;

      if (exp_q.size() != 0) begin
         rsp = exp_q.pop_front();
         if (rsp[1]) begin
            e_dm_rv = 1'b1;
            e_dm_rd = rsp[0] ? '0 : mem_rdata_i;
         end else begin
            e_if_rv = 1'b1;
            e_if_rd = mem_rdata_i;
         end
      end else begin
         if (if_req_i && dm_req_i) begin
            m_conf++;
            who = (m_last_who == WHO_DM) ? WHO_IF : WHO_DM;
         end else if (if_req_i) begin
            who = WHO_IF;
         end else if (dm_req_i) begin
            who = WHO_DM;
         end
         if (who == WHO_IF) begin
            e_if_gnt = 1'b1;
            e_addr   = if_addr_i;
            exp_q.push_back(2'b00);
            m_last_who = WHO_IF;
         end else if (who == WHO_DM) begin
            e_dm_gnt = 1'b1;
            e_addr   = dm_addr_i;
            e_wdata  = dm_wdata_i;
            e_st     = dm_we_i;
            exp_q.push_back({1'b1, dm_we_i});
            m_last_who = WHO_DM;
         end
      end

      chk("rnd_if_gnt",    64'(if_gnt_o),    64'(e_if_gnt));
      chk("rnd_dm_gnt",    64'(dm_gnt_o),    64'(e_dm_gnt));
      chk("rnd_mem_addr",  64'(mem_addr_o),  64'(e_addr));
      chk("rnd_mem_wdata", 64'(mem_wdata_o), 64'(e_wdata));
      chk("rnd_mem_st_en", 64'(mem_st_en_o), 64'(e_st));
      chk("rnd_if_rvalid", 64'(if_rvalid_o), 64'(e_if_rv));
      chk("rnd_if_rdata",  64'(if_rdata_o),  64'(e_if_rd));
      chk("rnd_dm_rvalid", 64'(dm_rvalid_o), 64'(e_dm_rv));
      chk("rnd_dm_rdata",  64'(dm_rdata_o),  64'(e_dm_rd));

      m_if_granted = e_if_gnt;
      m_dm_granted = e_dm_gnt;
   endtask

   // ---------------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------------
   initial begin
      rst_ni = 1'b0;
      clear_inputs();

      // ---- reset state, with both requests raised while reset is held ------
      if_req_i  = 1'b1;
      if_addr_i = 32'h0000_1111;
      dm_req_i  = 1'b1;
      dm_we_i   = 1'b1;
      dm_addr_i = 32'h0000_2222;
      @(negedge clk_i);
      @(negedge clk_i);
      chk("rst_if_gnt",     64'(if_gnt_o),    64'd0);
      chk("rst_dm_gnt",     64'(dm_gnt_o),    64'd0);
      chk("rst_if_rvalid",  64'(if_rvalid_o), 64'd0);
      chk("rst_dm_rvalid",  64'(dm_rvalid_o), 64'd0);
      chk("rst_conf_cnt",   64'(conf_cnt_o),  64'd0);
      chk("rst_state",      64'(state_o),     64'(ST_IDLE));
      chk("rst_mem_st_en",  64'(mem_st_en_o), 64'd0);
      chk("rst_mem_addr",   64'(mem_addr_o),  64'd0);

      // ---- table-driven vectors --------------------------------------------
      //                 ifr  if_addr      dmr  we   dm_addr      wdata        mem_rdata     gi   gd   exp_addr     exp_wdata    st   rsp   exp_rdata
      vecs[0] = '{1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_00A1, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 1'b0, 2'd1, 32'h0000_00A1};
      vecs[1] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0099, 32'h0000_00B2, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_0099, 1'b0, 2'd2, 32'h0000_00B2};
      vecs[2] = '{1'b1, 32'h0000_0300, 1'b1, 1'b1, 32'h0000_0400, 32'h0000_0011, 32'h0000_00C3, 1'b1, 1'b0, 32'h0000_0300, 32'h0000_0000, 1'b0, 2'd1, 32'h0000_00C3};
      vecs[3] = '{1'b1, 32'h0000_0300, 1'b1, 1'b1, 32'h0000_0400, 32'h0000_0011, 32'h0000_00D4, 1'b0, 1'b1, 32'h0000_0400, 32'h0000_0011, 1'b1, 2'd2, 32'h0000_0000};
      vecs[4] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0500, 32'h0000_0022, 32'h0000_00E5, 1'b0, 1'b1, 32'h0000_0500, 32'h0000_0022, 1'b1, 2'd2, 32'h0000_0000};
      vecs[5] = '{1'b0, 32'h0000_0600, 1'b0, 1'b1, 32'h0000_06A0, 32'h0000_0055, 32'h0000_00F6, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 2'd0, 32'h0000_0000};
      vecs[6] = '{1'b1, 32'h0000_0700, 1'b1, 1'b0, 32'h0000_0800, 32'h0000_0033, 32'h0000_0077, 1'b1, 1'b0, 32'h0000_0700, 32'h0000_0000, 1'b0, 2'd1, 32'h0000_0077};
      vecs[7] = '{1'b1, 32'h0000_0900, 1'b1, 1'b0, 32'h0000_0A00, 32'h0000_0044, 32'h0000_0088, 1'b0, 1'b1, 32'h0000_0A00, 32'h0000_0044, 1'b0, 2'd2, 32'h0000_0088};

      do_reset();
      for (int v = 0; v < N_VEC; v++) begin
         if (v > 0) next_cycle();
         if_req_i    = vecs[v].if_req;
         if_addr_i   = vecs[v].if_addr;
         dm_req_i    = vecs[v].dm_req;
         dm_we_i     = vecs[v].dm_we;
         dm_addr_i   = vecs[v].dm_addr;
         dm_wdata_i  = vecs[v].dm_wdata;
         mem_rdata_i = '0;
         @(negedge clk_i);
         chk($sformatf("vec%0d_if_gnt", v),    64'(if_gnt_o),    64'(vecs[v].exp_if_gnt));
         chk($sformatf("vec%0d_dm_gnt", v),    64'(dm_gnt_o),    64'(vecs[v].exp_dm_gnt));
         chk($sformatf("vec%0d_mem_addr", v),  64'(mem_addr_o),  64'(vecs[v].exp_addr));
         chk($sformatf("vec%0d_mem_wdata", v), 64'(mem_wdata_o), 64'(vecs[v].exp_wdata));
         chk($sformatf("vec%0d_mem_st_en", v), 64'(mem_st_en_o), 64'(vecs[v].exp_st));

         next_cycle();
         if_req_i    = 1'b0;
         dm_req_i    = 1'b0;
         mem_rdata_i = vecs[v].mem_rdata;
         @(negedge clk_i);
         chk($sformatf("vec%0d_if_rvalid", v), 64'(if_rvalid_o), 64'(vecs[v].exp_rsp == 2'd1));
         chk($sformatf("vec%0d_dm_rvalid", v), 64'(dm_rvalid_o), 64'(vecs[v].exp_rsp == 2'd2));
         chk($sformatf("vec%0d_if_rdata", v),  64'(if_rdata_o),
             (vecs[v].exp_rsp == 2'd1) ? 64'(vecs[v].exp_rdata) : 64'd0);
         chk($sformatf("vec%0d_dm_rdata", v),  64'(dm_rdata_o),
             (vecs[v].exp_rsp == 2'd2) ? 64'(vecs[v].exp_rdata) : 64'd0);
         chk($sformatf("vec%0d_rsp_no_gnt", v), 64'(if_gnt_o | dm_gnt_o), 64'd0);
      end
      // Rows 2, 3, 6 and 7 had both requests pending in IDLE.
      chk("vec_conf_cnt",     64'(conf_cnt_o),   64'd4);
      chk("vec_conf_cnt_sat", 64'(sat_conf_cnt), 64'd3);

      // ---- single load ------------------------------------------------------
      do_reset();
      dm_req_i  = 1'b1;
      dm_we_i   = 1'b0;
      dm_addr_i = 32'h0000_2000;
      @(negedge clk_i);
      chk("load_c0_dm_gnt",    64'(dm_gnt_o),    64'd1);
      chk("load_c0_mem_st_en", 64'(mem_st_en_o), 64'd0);
      chk("load_c0_mem_addr",  64'(mem_addr_o),  64'h2000);
      next_cycle();
      dm_req_i    = 1'b0;
      mem_rdata_i = 32'hDEAD_BEEF;
      @(negedge clk_i);
      chk("load_c1_dm_rvalid", 64'(dm_rvalid_o), 64'd1);
      chk("load_c1_dm_rdata",  64'(dm_rdata_o),  64'hDEAD_BEEF);
      next_cycle();
      mem_rdata_i = 32'h1234_5678;
      @(negedge clk_i);
      chk("load_c2_state",     64'(state_o),     64'(ST_IDLE));
      chk("load_c2_dm_rvalid", 64'(dm_rvalid_o), 64'd0);
      chk("load_c2_dm_rdata",  64'(dm_rdata_o),  64'd0);
      chk("load_c2_if_rdata",  64'(if_rdata_o),  64'd0);

      // ---- store ------------------------------------------------------------
      next_cycle();
      dm_req_i   = 1'b1;
      dm_we_i    = 1'b1;
      dm_addr_i  = 32'h0000_0880;
      dm_wdata_i = 32'h0000_005A;
      @(negedge clk_i);
      chk("store_c0_dm_gnt",    64'(dm_gnt_o),    64'd1);
      chk("store_c0_mem_st_en", 64'(mem_st_en_o), 64'd1);
      chk("store_c0_mem_addr",  64'(mem_addr_o),  64'h0880);
      chk("store_c0_mem_wdata", 64'(mem_wdata_o), 64'h005A);
      next_cycle();
      dm_req_i    = 1'b0;
      dm_we_i     = 1'b0;
      mem_rdata_i = 32'hFFFF_FFFF;
      @(negedge clk_i);
      chk("store_c1_dm_rvalid", 64'(dm_rvalid_o), 64'd1);
      chk("store_c1_dm_rdata",  64'(dm_rdata_o),  64'd0);
      chk("store_c1_mem_st_en", 64'(mem_st_en_o), 64'd0);

      // ---- conflict after reset, and counter saturation ---------------------
      do_reset();
      for (int c = 0; c < 10; c++) begin
         if (c > 0) next_cycle();
         if_req_i  = 1'b1;
         if_addr_i = 32'h0000_1000;
         dm_req_i  = 1'b1;
         dm_we_i   = 1'b0;
         dm_addr_i = 32'h0000_3000;
         @(negedge clk_i);
         // Grants on even cycles, alternating dm, if, dm, if, dm.
         chk($sformatf("conf_c%0d_dm_gnt", c), 64'(dm_gnt_o),
             64'((c % 2 == 0) && ((c / 2) % 2 == 0)));
         chk($sformatf("conf_c%0d_if_gnt", c), 64'(if_gnt_o),
             64'((c % 2 == 0) && ((c / 2) % 2 == 1)));
         if (c == 7) chk("conf_cnt_after_8", 64'(conf_cnt_o), 64'd4);
      end
      chk("conf_cnt_after_10",     64'(conf_cnt_o),   64'd5);
      chk("conf_cnt_sat_after_10", 64'(sat_conf_cnt), 64'd3);
      next_cycle();
      clear_inputs();
      @(negedge clk_i);

      // ---- reset in the RSP_IF cycle ----------------------------------------
      do_reset();
      if_req_i  = 1'b1;
      if_addr_i = 32'h0000_0044;
      @(negedge clk_i);
      chk("rstmid_c0_if_gnt", 64'(if_gnt_o), 64'd1);
      next_cycle();
      rst_ni      = 1'b0;
      mem_rdata_i = 32'hBAD0_BAD0;
      @(negedge clk_i);
      chk("rstmid_in_rst_if_rvalid", 64'(if_rvalid_o), 64'd0);
      chk("rstmid_in_rst_if_gnt",    64'(if_gnt_o),    64'd0);
      chk("rstmid_in_rst_if_rdata",  64'(if_rdata_o),  64'd0);
      next_cycle();
      rst_ni    = 1'b1;
      if_addr_i = 32'h0000_0048;
      @(negedge clk_i);
      chk("rstmid_rel_if_rvalid", 64'(if_rvalid_o), 64'd0);
      chk("rstmid_rel_if_gnt",    64'(if_gnt_o),    64'd1);
      chk("rstmid_rel_mem_addr",  64'(mem_addr_o),  64'h0048);
      next_cycle();
      if_req_i    = 1'b0;
      mem_rdata_i = 32'h0000_1234;
      @(negedge clk_i);
      chk("rstmid_new_if_rvalid", 64'(if_rvalid_o), 64'd1);
      chk("rstmid_new_if_rdata",  64'(if_rdata_o),  64'h1234);

      // ---- randomized traffic against the reference model -------------------
      do_reset();
      model_reset();
      for (int c = 0; c < 800; c++) begin
         if (c > 0) next_cycle();
         // A requester may start a new request once idle or once granted;
         // otherwise it holds its fields, occasionally giving up.
         if (!if_req_i || m_if_granted) begin
            if_req_i  = ($urandom_range(0, 99) < 55);
            if_addr_i = $urandom;
         end else if ($urandom_range(0, 9) == 0) begin
            if_req_i = 1'b0;
         end
         if (!dm_req_i || m_dm_granted) begin
            dm_req_i   = ($urandom_range(0, 99) < 55);
            dm_we_i    = $urandom_range(0, 1) == 1;
            dm_addr_i  = $urandom;
            dm_wdata_i = $urandom;
         end else if ($urandom_range(0, 9) == 0) begin
            dm_req_i = 1'b0;
         end
         mem_rdata_i = $urandom;
         @(negedge clk_i);
         model_check();
      end

      next_cycle();
      clear_inputs();
      @(negedge clk_i);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lsu_arb.md
LSU_ARB -- requirements
Module: lsu_arb

Interface
REQ-001 Parameter: AW, 32, address width of all ports.
REQ-002 Parameter: DW, 32, data width of all ports.
REQ-003 Parameter: CW, 16, width of the conflict counter.
REQ-004 Ports:
- clk_i  in  1  single clock; all state on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- if_req_i  in  1  fetch requester: read request.
- if_addr_i  in  AW  fetch requester: read address.
- if_gnt_o  out  1  fetch requester: request accepted this cycle.
- if_rvalid_o  out  1  fetch requester: read data valid.
- if_rdata_o  out  DW  fetch requester: read data.
- dm_req_i  in  1  data requester: request.
- dm_we_i  in  1  data requester: 1 = store, 0 = load.
- dm_addr_i  in  AW  data requester: address.
- dm_wdata_i  in  DW  data requester: store data.
- dm_gnt_o  out  1  data requester: request accepted this cycle.
- dm_rvalid_o  out  1  data requester: response valid (load data or store ack).
- dm_rdata_o  out  DW  data requester: load data.
- mem_addr_o  out  AW  shared memory/IO unit: address.
- mem_wdata_o  out  DW  shared memory/IO unit: store data.
- mem_st_en_o  out  1  shared memory/IO unit: store enable.
- mem_rdata_i  in  DW  shared memory/IO unit: load data, registered, valid 1 cycle after address.
- conf_cnt_o  out  CW  count of cycles with both requests pending in IDLE.

Function
REQ-005 The FSM SHALL have states IDLE, RSP_IF and RSP_DM.
REQ-006 In IDLE with at least one request, the block SHALL choose a winner combinationally in the same cycle:
- assert the winner's gnt_o;
- drive the winner's address to mem_addr_o;
- if the winner is dm, drive dm_wdata_i to mem_wdata_o and dm_we_i to mem_st_en_o.
REQ-007 After a grant, the next state SHALL be RSP_IF or RSP_DM (the winner's).
REQ-008 In RSP_x, the block SHALL:
- assert x_rvalid_o for exactly one cycle;
- drive x_rdata_o = mem_rdata_i for loads and 0 for stores;
- return to IDLE on the next edge.
REQ-009 No grant SHALL be issued in RSP_x, so at most one transaction is in flight. Issue rate is at most one grant per 2 cycles.
REQ-010 Arbitration SHALL be round-robin using a 1-bit last-winner register, updated on every grant. With both requests pending, the requester that did not win last time wins.
REQ-011 With a single request pending, that requester SHALL win regardless of the last-winner register.
REQ-012 A requester SHALL hold req and its address/data/we stable until it sees gnt. The block does not latch request fields before grant.
REQ-013 mem_st_en_o SHALL be high only in the grant cycle of a dm store; it is 0 in all other cycles.
REQ-014 When no grant occurs, mem_addr_o, mem_wdata_o and mem_st_en_o SHALL be 0.
REQ-015 Both gnt_o outputs SHALL never be high in the same cycle. Both rvalid_o outputs SHALL never be high in the same cycle.
REQ-016 When no rvalid is high, if_rdata_o and dm_rdata_o SHALL be 0.
REQ-017 conf_cnt_o SHALL increment by 1 on each IDLE cycle with if_req_i and dm_req_i both high, and SHALL saturate at 2^CW-1 (no wrap).
REQ-018 A request dropped before it is granted SHALL be ignored: no grant, no response, no state change.

Reset
REQ-019 Asserting rst_ni low SHALL asynchronously force:
- FSM to IDLE;
- last-winner to "if", so dm wins the first conflict;
- conf_cnt_o to 0;
- all gnt and rvalid outputs to 0.
REQ-020 Reset during RSP_x SHALL discard the pending response: no rvalid after reset release.
REQ-021 Reset release SHALL be synchronous to clk_i. The first grant is possible in the first cycle rst_ni is high.

Verification
REQ-022 Single load: dm_req=1, we=0, addr=0x2000, mem_rdata=0xDEADBEEF next cycle -> dm_gnt in cycle 0, mem_st_en=0, dm_rvalid in cycle 1 with dm_rdata=0xDEADBEEF, state IDLE in cycle 2.
REQ-023 Store: dm_req=1, we=1, addr=0x0880, wdata=0x5A -> cycle 0: dm_gnt=1, mem_st_en=1, mem_addr=0x0880, mem_wdata=0x5A; cycle 1: dm_rvalid=1, dm_rdata=0.
REQ-024 Conflict after reset: if_req and dm_req held high for 8 cycles -> grants alternate dm, if, dm, if at cycles 0, 2, 4, 6; conf_cnt_o=4 at the end.
REQ-025 Saturation: CW=2, continuous conflict for 10 cycles -> conf_cnt_o stops at 3.
REQ-026 Reset mid-transaction: rst_ni low in the RSP_IF cycle -> if_rvalid stays 0; after release with if_req=1, a new grant occurs in the first cycle.
REQ-027 Assertions on random traffic:
- gnt outputs mutually exclusive;
- each gnt followed by exactly one rvalid to the same requester one cycle later;
- mem_st_en_o only in dm store grant cycles.
